// File: rtl/zsdram_lcd_prefetch_if.sv
// zsdram_lcd_prefetch_if
// Bundles the arbiter read port and the LCD pixel pop port of the frame-buffer
// prefetcher.
//   master : prefetcher side. Drives oRd_Req/oRd_Addr and oPix_Data/oPix_Valid.
//            Receives iRd_Done, iRd_Data1..4 and iPix_Rd.
//   slave  : arbiter/LCD side, with the directions reversed.
interface zsdram_lcd_prefetch_if;
  logic        oRd_Req;
  logic [23:0] oRd_Addr;
  logic        iRd_Done;
  logic [15:0] iRd_Data1;
  logic [15:0] iRd_Data2;
  logic [15:0] iRd_Data3;
  logic [15:0] iRd_Data4;
  logic        iPix_Rd;
  logic [15:0] oPix_Data;
  logic        oPix_Valid;

  modport master (
    output oRd_Req, oRd_Addr, oPix_Data, oPix_Valid,
    input  iRd_Done, iRd_Data1, iRd_Data2, iRd_Data3, iRd_Data4, iPix_Rd
  );

  modport slave (
    input  oRd_Req, oRd_Addr, oPix_Data, oPix_Valid,
    output iRd_Done, iRd_Data1, iRd_Data2, iRd_Data3, iRd_Data4, iPix_Rd
  );
endinterface

// File: rtl/zsdram_lcd_prefetch.sv
// zsdram_lcd_prefetch
// This module streams a frame buffer out of SDRAM to the LCD pixel path.
// - It issues 4-word burst reads to the arbiter.
// - It buffers the returned words in a FIFO.
// - It presents the FIFO head word to the LCD timing generator.
// A pulse on iVsync flushes the FIFO and rewinds to the start of the frame.
// Ports:
//   clk, rst_n     : system clock and asynchronous active-low reset.
//   en             : 1 lets the module issue new requests.
//                    When it is 0, an in-flight burst still completes.
//   iVsync         : one-cycle pulse that marks the start of a new frame.
//   bus (master)   : carries the arbiter read port (oRd_Req, oRd_Addr,
//                    iRd_Done, iRd_Data1..4).
//                    Also carries the pixel port (iPix_Rd, oPix_Data, oPix_Valid).
//   oUnderrun_Cnt  : counts pops requested while the FIFO was empty.
// Optional feature: define ZSDRAM_PREFETCH_UNDERRUN_EN to build the saturating
// underrun counter. Without that define, oUnderrun_Cnt is tied to zero.
module zsdram_lcd_prefetch #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          FRAME_WORDS = 32'd130560,
  parameter int          FIFO_DEPTH  = 32'd16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         iVsync,
  zsdram_lcd_prefetch_if.master        bus,
  output logic [15:0]                  oUnderrun_Cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] FOUR_C  = CW'(32'd4);
  localparam logic [CW-1:0] ONE_CW  = CW'(32'd1);
  localparam logic [AW-1:0] ONE_AW  = AW'(32'd1);
  localparam logic [23:0]   FRAME_C = 24'(FRAME_WORDS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  logic [1:0]    state_r;
  logic          rd_req_r;
  logic [23:0]   rd_addr_r;
  logic [23:0]   offset_r;
  logic          flush_pend_r;
  logic [1:0]    fill_idx_r;
  logic [15:0]   burst_r [4];

  logic [15:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [15:0]   pix_data_r;
  logic          pix_valid_r;

  logic          push_s;
  logic          pop_s;
  logic          flush_s;
  logic          space_ok_s;
  logic [15:0]   push_data_s;
  logic [CW-1:0] free_s;
  logic [23:0]   offset_inc_s;
  logic [23:0]   offset_wrap_s;
  logic [AW-1:0] rd_ptr_next_s;
  logic [CW-1:0] count_next_s;
  logic [15:0]   head_next_s;

  // Derive the datapath controls from the current state.
  always_comb begin
    push_s       = (state_r == ST_FILL);
    flush_s      = (state_r == ST_FLUSH);
    // pix_valid_r mirrors count_r != 0, so it gates pops without another compare.
    pop_s        = bus.iPix_Rd && pix_valid_r;
    push_data_s  = burst_r[fill_idx_r];
    free_s       = DEPTH_C - count_r;
    space_ok_s   = (free_s >= FOUR_C);
    offset_inc_s = offset_r + 24'd4;
    if (offset_inc_s == FRAME_C) begin
      offset_wrap_s = 24'd0;
    end else begin
      offset_wrap_s = offset_inc_s;
    end
  end

  // Compute the next read pointer and the next occupancy of the FIFO.
  always_comb begin
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (flush_s) begin
      rd_ptr_next_s = {AW{1'b0}};
      count_next_s  = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + ONE_AW;
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + ONE_CW;
        2'b01:   count_next_s = count_r - ONE_CW;
        default: count_next_s = count_r;
      endcase
    end
  end

  // Select the word the registered head output will show next cycle.
  // A word being pushed into an empty, or emptying, FIFO bypasses the memory.
  always_comb begin
    if (count_next_s == {CW{1'b0}}) begin
      head_next_s = 16'h0000;
    end else if ((count_r == {CW{1'b0}}) || ((count_r == ONE_CW) && pop_s)) begin
      head_next_s = push_data_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Run the request/fill/flush sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rd_req_r     <= 1'b0;
      rd_addr_r    <= BASE_ADDR;
      offset_r     <= 24'd0;
      flush_pend_r <= 1'b0;
      fill_idx_r   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        burst_r[i] <= 16'h0000;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (iVsync) begin
            state_r <= ST_FLUSH;
          end else if (en && space_ok_s) begin
            state_r   <= ST_REQ;
            rd_req_r  <= 1'b1;
            rd_addr_r <= BASE_ADDR + offset_r;
          end
        end
        ST_REQ: begin
          // The arbiter is already committed, so a vsync only marks the data for discard.
          if (iVsync) begin
            flush_pend_r <= 1'b1;
          end
          if (bus.iRd_Done) begin
            rd_req_r <= 1'b0;
            if (flush_pend_r || iVsync) begin
              flush_pend_r <= 1'b0;
              state_r      <= ST_FLUSH;
            end else begin
              burst_r[0] <= bus.iRd_Data1;
              burst_r[1] <= bus.iRd_Data2;
              burst_r[2] <= bus.iRd_Data3;
              burst_r[3] <= bus.iRd_Data4;
              fill_idx_r <= 2'd0;
              state_r    <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (iVsync) begin
            state_r <= ST_FLUSH;
          end else begin
            fill_idx_r <= fill_idx_r + 2'd1;
            if (fill_idx_r == 2'd3) begin
              offset_r <= offset_wrap_s;
              state_r  <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          offset_r <= 24'd0;
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          rd_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Update the FIFO pointers, the occupancy and the registered head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      pix_data_r  <= 16'h0000;
      pix_valid_r <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= {AW{1'b0}};
      end else if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_AW;
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      pix_data_r  <= head_next_s;
      pix_valid_r <= (count_next_s != {CW{1'b0}});
    end
  end

  // Write into the FIFO storage. The storage needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

`ifdef ZSDRAM_PREFETCH_UNDERRUN_EN
  logic [15:0] underrun_r;

  // Count pops requested while the FIFO is empty. The count saturates, and vsync clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_r <= 16'h0000;
    end else if (iVsync) begin
      underrun_r <= 16'h0000;
    end else if (bus.iPix_Rd && !pix_valid_r && (underrun_r != 16'hFFFF)) begin
      underrun_r <= underrun_r + 16'd1;
    end
  end

  assign oUnderrun_Cnt = underrun_r;
`else
  assign oUnderrun_Cnt = 16'h0000;
`endif

  assign bus.oRd_Req    = rd_req_r;
  assign bus.oRd_Addr   = rd_addr_r;
  assign bus.oPix_Data  = pix_data_r;
  assign bus.oPix_Valid = pix_valid_r;

endmodule
